// File: rtl/pipelined_mux_n.sv
// Purpose: select one of NUM_IN words (out-of-range select -> 0 + error flag) and carry it through STAGES registers.
// Latency: STAGES cycles from acceptance to data_out when never stalled; 1 word/cycle sustained.
// Backpressure: valid/ready ready-chain, bubbles collapse, stalled stages hold; flush drops all in-flight entries.
module pipelined_mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int STAGES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_sel_err,
  output logic                    err_sticky
);

  logic [WIDTH-1:0]  w_sel_dat;
  logic              w_sel_err;
  logic [STAGES-1:0] w_vld;
  // w_rdy[STAGES] is the downstream ready so every stage uses the same rule
  logic [STAGES:0]   w_rdy;
  // w_mov[i] = a word enters stage i this cycle; w_mov[STAGES] = a word leaves the block
  logic [STAGES:0]   w_mov;

  // Input select: out-of-range index yields a zero word tagged as an error
  always_comb begin
    w_sel_dat = '0;
    w_sel_err = (32'(sel) >= NUM_IN);
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_sel_dat = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Ready chain from the output back to the input, then the per-stage transfer strobes
  always_comb begin
    w_rdy         = '0;
    w_mov         = '0;
    w_rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_rdy[i] = !w_vld[i] || w_rdy[i+1];
    end
    w_mov[0] = in_valid && w_rdy[0] && !flush;
    for (int i = 0; i < STAGES; i++) begin
      w_mov[i+1] = w_vld[i] && w_rdy[i+1];
    end
  end

  // A flush cycle refuses new input so the offered word is never captured
  assign in_ready = w_rdy[0] && !flush;

  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    logic             r_vld;
    logic             r_err;
    logic [WIDTH-1:0] r_dat;
    logic [WIDTH-1:0] w_src_dat;
    logic             w_src_err;

    if (i == 0) begin : g_head
      assign w_src_dat = w_sel_dat;
      assign w_src_err = w_sel_err;
    end else begin : g_body
      assign w_src_dat = g_stg[i-1].r_dat;
      assign w_src_err = g_stg[i-1].r_err;
    end

    // Stage register: load on incoming move, empty when contents move on, otherwise hold
    always_ff @(posedge clk) begin
      if (reset) begin
        r_vld <= 1'b0;
        r_err <= 1'b0;
        r_dat <= '0;
      end else if (flush) begin
        r_vld <= 1'b0;
      end else if (w_mov[i]) begin
        r_vld <= 1'b1;
        r_dat <= w_src_dat;
        r_err <= w_src_err;
      end else if (w_mov[i+1]) begin
        r_vld <= 1'b0;
      end
    end

    assign w_vld[i] = r_vld;
  end

  assign out_valid   = g_stg[STAGES-1].r_vld;
  assign data_out    = g_stg[STAGES-1].r_dat;
  assign out_sel_err = g_stg[STAGES-1].r_err;

  // Sticky error: any accepted out-of-range select, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky <= 1'b0;
    end else if (w_mov[0] && w_sel_err) begin
      err_sticky <= 1'b1;
    end
  end

endmodule
